// File: rtl/round_ctrl.sv
// round_ctrl: reaction-game round sequencer.
// Synchronises both push buttons, runs the IDLE -> DELAY -> LIGHT -> RESULT ->
// HOLDOFF round cycle and emits registered leds_on / winrnd / right / tie.
// Optional build macro ROUND_RANDOM_DELAY_EN: adds a 16-bit LFSR that
// randomises the DELAY length (MIN_DELAY + lfsr[DELAY_W-1:0]); without it
// every round uses MIN_DELAY.
`timescale 1ns/1ps

module round_ctrl #(
   parameter int unsigned MIN_DELAY = 1000,
   parameter int unsigned DELAY_W   = 10,
   parameter int unsigned TIMEOUT   = 2000,
   parameter int unsigned HOLD_CYC  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pb_l,
   input  logic pb_r,
   input  logic game_over,
   output logic leds_on,
   output logic winrnd,
   output logic right,
   output logic tie
);

   // Release counter only needs to reach HOLD_CYC-1.
   localparam int unsigned RW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      LIGHT,
      RESULT,
      HOLDOFF
   } state_t;

   state_t        state, state_n;
   logic [15:0]   cnt, cnt_n;
   logic [RW-1:0] rel, rel_n;
   logic          leds_n, winrnd_n, right_n, tie_n;

   // [0]/[1] form the synchroniser, [2] is the history flop for edge detect.
   logic [2:0]    sync_l, sync_r;
   logic          lvl_l, lvl_r, press_l, press_r;
   logic [15:0]   delay_val;

   // Two-flop synchronisers plus one history flop per button.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_l <= '0;
         sync_r <= '0;
      end else begin
         sync_l <= {sync_l[1:0], pb_l};
         sync_r <= {sync_r[1:0], pb_r};
      end
   end

   assign lvl_l   = sync_l[1];
   assign lvl_r   = sync_r[1];
   assign press_l = sync_l[1] & ~sync_l[2];
   assign press_r = sync_r[1] & ~sync_r[2];

`ifdef ROUND_RANDOM_DELAY_EN
   logic [15:0] lfsr;

   // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1, stepping every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end

   assign delay_val = 16'(MIN_DELAY) + 16'(lfsr[DELAY_W-1:0]);
`else
   assign delay_val = 16'(MIN_DELAY);
`endif

   // Round sequencing; outputs are computed for the next cycle and registered.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rel_n    = rel;
      leds_n   = leds_on;
      winrnd_n = 1'b0;
      tie_n    = 1'b0;
      right_n  = right;
      case (state)
         IDLE: begin
            leds_n = 1'b0;
            rel_n  = '0;
            if (!game_over && !lvl_l && !lvl_r) begin
               state_n = DELAY;
               cnt_n   = delay_val;
            end
         end
         DELAY: begin
            leds_n = 1'b0;
            if (press_l || press_r) begin
               // Jumped the light: result decided now, lights stay off.
               state_n  = RESULT;
               winrnd_n = press_l ^ press_r;
               tie_n    = press_l & press_r;
               if (press_l ^ press_r) begin
                  right_n = press_r;
               end
            end else if (cnt == 16'd1) begin
               state_n = LIGHT;
               cnt_n   = 16'(TIMEOUT);
               leds_n  = 1'b1;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         LIGHT: begin
            leds_n = 1'b1;
            if (press_l || press_r) begin
               state_n  = RESULT;
               winrnd_n = press_l ^ press_r;
               tie_n    = press_l & press_r;
               if (press_l ^ press_r) begin
                  right_n = press_r;
               end
            end else if (cnt == 16'd1) begin
               state_n = HOLDOFF;
               tie_n   = 1'b1;
               leds_n  = 1'b0;
               rel_n   = '0;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         RESULT: begin
            state_n = HOLDOFF;
            leds_n  = 1'b0;
            rel_n   = '0;
         end
         HOLDOFF: begin
            leds_n = 1'b0;
            if (lvl_l || lvl_r) begin
               rel_n = '0;
            end else if (rel == RW'(HOLD_CYC - 1)) begin
               state_n = IDLE;
               rel_n   = '0;
            end else begin
               rel_n = rel + RW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            leds_n  = 1'b0;
            rel_n   = '0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rel     <= '0;
         leds_on <= 1'b0;
         winrnd  <= 1'b0;
         tie     <= 1'b0;
         right   <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         rel     <= rel_n;
         leds_on <= leds_n;
         winrnd  <= winrnd_n;
         tie     <= tie_n;
         right   <= right_n;
      end
   end

endmodule
